// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB-Lite arbiter: NUM_M masters share one 16-bit address, 32-bit data slave.
// Define ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins fixed priority.
module ahb_rr_arbiter #(
  parameter int NUM_M = 2
) (
  input  logic                HCLK,
  input  logic                HRSTN,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M*16-1:0] m_haddr,
  input  logic [NUM_M*2-1:0]  m_htrans,
  input  logic [NUM_M-1:0]    m_hwrite,
  input  logic [NUM_M*3-1:0]  m_hsize,
  input  logic [NUM_M*32-1:0] m_hwdata,
  output logic [NUM_M-1:0]    m_gnt,
  output logic                m_hready,
  output logic                m_hresp,
  output logic [31:0]         m_hrdata,
  output logic                HSEL,
  output logic [15:0]         HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [31:0]         HWDATA,
  output logic                HREADY,
  input  logic                HREADYOUT,
  input  logic                HRESP,
  input  logic [31:0]         HRDATA
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  logic [NUM_M-1:0] gnt_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    own_q;
  logic             data_vld;

  logic [IW-1:0]    a_idx;
  logic             a_req;
  logic [1:0]       a_trans;
  logic [15:0]      a_addr;
  logic             a_write;
  logic [2:0]       a_size;
  logic             hold;
  logic             win_found;
  logic [IW-1:0]    win_idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    a_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_q[i]) a_idx = IW'(i);
    end
  end

  always_comb begin
    a_req   = m_req[a_idx];
    a_trans = m_htrans[int'(a_idx)*2 +: 2];
    a_addr  = m_haddr[int'(a_idx)*16 +: 16];
    a_write = m_hwrite[a_idx];
    a_size  = m_hsize[int'(a_idx)*3 +: 3];
  end

  // An owner in the middle of a burst keeps the bus; bursts are never split.
  assign hold = a_req && (a_trans == TR_SEQ || a_trans == TR_BUSY);

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (m_req[k]) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 1; k <= NUM_M; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_M;
      if (!win_found && m_req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge HCLK) begin
    if (HRSTN) begin
      gnt_q    <= NUM_M'(1);
      ptr_q    <= '0;
      data_vld <= 1'b0;
      own_q    <= '0;
    end else if (HREADYOUT) begin
      data_vld <= HSEL & HTRANS[1];
      own_q    <= a_idx;
      if (!hold && win_found) begin
        gnt_q <= NUM_M'(1) << win_idx;
        ptr_q <= win_idx;
      end
    end
  end

  // Reset also blanks the address phase so nothing leaks to the slave while held in reset.
  assign HSEL   = ~HRSTN & a_req;
  assign HTRANS = HSEL ? a_trans : TR_IDLE;
  assign HADDR  = HRSTN ? 16'h0 : a_addr;
  assign HWRITE = ~HRSTN & a_write;
  assign HSIZE  = HRSTN ? 3'd0 : a_size;
  assign HWDATA = (data_vld && !HRSTN) ? m_hwdata[int'(own_q)*32 +: 32] : 32'h0;

  assign m_gnt    = gnt_q;
  assign HREADY   = HREADYOUT;
  assign m_hready = HREADYOUT;
  assign m_hresp  = HRESP;
  assign m_hrdata = HRDATA;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter with two masters; inputs and checks happen at the falling edge.
module tb_ahb_rr_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] SQ   = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRSTN;
  logic [1:0]  m_req;
  logic [15:0] addr [2];
  logic [1:0]  tr   [2];
  logic        wr   [2];
  logic [2:0]  sz   [2];
  logic [31:0] wd   [2];
  logic [31:0] m_haddr_w;
  logic [3:0]  m_htrans;
  logic [1:0]  m_hwrite;
  logic [5:0]  m_hsize;
  logic [63:0] m_hwdata;
  logic [1:0]  m_gnt;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA, HRDATA;

  int passed = 0;
  int total  = 0;

  assign m_haddr_w = {addr[1], addr[0]};
  assign m_htrans  = {tr[1], tr[0]};
  assign m_hwrite  = {wr[1], wr[0]};
  assign m_hsize   = {sz[1], sz[0]};
  assign m_hwdata  = {wd[1], wd[0]};

  always #5 HCLK = ~HCLK;

  ahb_rr_arbiter #(.NUM_M(2)) dut (
    .HCLK(HCLK), .HRSTN(HRSTN),
    .m_req(m_req), .m_haddr(m_haddr_w), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hwdata(m_hwdata),
    .m_gnt(m_gnt), .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    HRSTN = 1'b1; m_req = 2'b11;
    tr[0] = NS; tr[1] = NS;
    addr[0] = 16'h1234; addr[1] = 16'h5678;
    wr[0] = 1'b1; wr[1] = 1'b1;
    sz[0] = 3'd2; sz[1] = 3'd2;
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
    HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;

    // Held in reset with both masters requesting.
    repeat (3) begin
      @(negedge HCLK); #1;
      chk("rst_gnt",    32'(m_gnt),  32'h1);
      chk("rst_hsel",   32'(HSEL),   32'h0);
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_haddr",  32'(HADDR),  32'h0);
      chk("rst_hwdata", HWDATA,      32'h0);
    end

    @(negedge HCLK); HRSTN = 1'b0; #1;
    chk("rel_gnt",  32'(m_gnt), 32'h1);
    chk("rel_hsel", 32'(HSEL),  32'h1);
    chk("rel_addr", 32'(HADDR), 32'h1234);

    @(negedge HCLK); m_req = 2'b00; tr[0] = IDLE; tr[1] = IDLE; #1;
`ifdef ARB_FIXED_PRIO_EN
    chk("rel_gnt1", 32'(m_gnt), 32'h1);
`else
    chk("rel_gnt1", 32'(m_gnt), 32'h2);
`endif
    chk("rel_wdata", HWDATA,    32'h1111_1111);
    chk("idle_hsel", 32'(HSEL), 32'h0);

`ifdef ARB_FIXED_PRIO_EN
    @(negedge HCLK); m_req = 2'b11; tr[0] = NS; tr[1] = NS; #1;
    chk("fp_park", 32'(m_gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK); #1;
      chk("fp_gnt",   32'(m_gnt), 32'h1);
      chk("fp_addr",  32'(HADDR), 32'h1234);
      chk("fp_wdata", HWDATA,     32'h1111_1111);
    end
    @(negedge HCLK); m_req = 2'b10; tr[0] = IDLE; #1;
    chk("fp_gnt_hold", 32'(m_gnt), 32'h1);
    chk("fp_hsel",     32'(HSEL),  32'h0);
    @(negedge HCLK); #1;
    chk("fp_m1_gnt",   32'(m_gnt),  32'h2);
    chk("fp_m1_addr",  32'(HADDR),  32'h5678);
    chk("fp_m1_trans", 32'(HTRANS), 32'(NS));
`else
    // Single write from parked-away master 0; its request must not leak before the grant.
    @(negedge HCLK);
    m_req = 2'b01; tr[0] = NS; addr[0] = 16'h0040; wr[0] = 1'b1; wd[0] = 32'hDEAD_BEEF; #1;
    chk("park_gnt",   32'(m_gnt), 32'h2);
    chk("iso_hsel",   32'(HSEL),  32'h0);
    chk("iso_wdata",  HWDATA,     32'h0);
    @(negedge HCLK); #1;
    chk("wr_gnt",    32'(m_gnt),  32'h1);
    chk("wr_hsel",   32'(HSEL),   32'h1);
    chk("wr_addr",   32'(HADDR),  32'h0040);
    chk("wr_trans",  32'(HTRANS), 32'(NS));
    chk("wr_write",  32'(HWRITE), 32'h1);
    chk("wr_size",   32'(HSIZE),  32'h2);
    @(negedge HCLK); m_req = 2'b00; tr[0] = IDLE; #1;
    chk("wr_data",   HWDATA,      32'hDEAD_BEEF);
    chk("wr_regnt",  32'(m_gnt),  32'h1);
    chk("wr_idle",   32'(HTRANS), 32'h0);

    // Round-robin between two continuous single-transfer masters.
    @(negedge HCLK);
    m_req = 2'b11; tr[0] = NS; tr[1] = NS;
    addr[0] = 16'h1000; addr[1] = 16'h2000;
    wd[0] = 32'hA0A0_A0A0; wd[1] = 32'hB1B1_B1B1; #1;
    chk("rr_wdata0", HWDATA,     32'h0);
    chk("rr_start",  32'(m_gnt), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK); #1;
      chk("rr_gnt",   32'(m_gnt), (i % 2 == 0) ? 32'h2 : 32'h1);
      chk("rr_addr",  32'(HADDR), (i % 2 == 0) ? 32'h2000 : 32'h1000);
      chk("rr_wdata", HWDATA,     (i % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1);
    end

    // Park on master 1, then master 0 runs an INCR4 with master 1 contending from beat 1.
    @(negedge HCLK); m_req = 2'b10; tr[0] = IDLE; tr[1] = NS;
    @(negedge HCLK); m_req = 2'b00; tr[1] = IDLE; #1;
    chk("solo_gnt", 32'(m_gnt), 32'h2);
    @(negedge HCLK); m_req = 2'b01; tr[0] = NS; addr[0] = 16'h0100; #1;
    chk("bst_pre_gnt", 32'(m_gnt), 32'h2);
    chk("bst_pre_sel", 32'(HSEL),  32'h0);
    for (int b = 0; b < 4; b++) begin
      @(negedge HCLK);
      tr[0]   = (b == 0) ? NS : SQ;
      addr[0] = 16'h0100 + 16'(4 * b);
      if (b >= 1) begin
        m_req = 2'b11; tr[1] = NS; addr[1] = 16'h2000;
        wd[0] = 32'hD000_0000 + 32'(b - 1);
      end
      #1;
      chk("bst_gnt",   32'(m_gnt),  32'h1);
      chk("bst_addr",  32'(HADDR),  32'h0100 + 32'(4 * b));
      chk("bst_trans", 32'(HTRANS), (b == 0) ? 32'(NS) : 32'(SQ));
      chk("bst_wdata", HWDATA,      (b == 0) ? 32'h0 : 32'hD000_0000 + 32'(b - 1));
    end
    @(negedge HCLK); m_req = 2'b10; tr[0] = IDLE; wd[0] = 32'hD000_0003; #1;
    chk("bst_last_gnt",  32'(m_gnt), 32'h1);
    chk("bst_last_sel",  32'(HSEL),  32'h0);
    chk("bst_last_data", HWDATA,     32'hD000_0003);

    // Master 1 takes over; master 0 queues a write whose data phase then sees wait states.
    @(negedge HCLK); m_req = 2'b11; tr[0] = NS; addr[0] = 16'h0300; #1;
    chk("sw_gnt",   32'(m_gnt),  32'h2);
    chk("sw_addr",  32'(HADDR),  32'h2000);
    chk("sw_trans", 32'(HTRANS), 32'(NS));
    chk("sw_wdata", HWDATA,      32'h0);
    @(negedge HCLK); #1;
    chk("ws_m0_gnt",  32'(m_gnt), 32'h1);
    chk("ws_m0_addr", 32'(HADDR), 32'h0300);
    chk("ws_m1_data", HWDATA,     32'hB1B1_B1B1);
    @(negedge HCLK);
    HREADYOUT = 1'b0; m_req = 2'b10; tr[0] = IDLE; wd[0] = 32'hCAFE_0300; #1;
    chk("ws_hready",   32'(HREADY),   32'h0);
    chk("ws_m_hready", 32'(m_hready), 32'h0);
    for (int s = 0; s < 2; s++) begin
      chk("ws_gnt",   32'(m_gnt), 32'h2);
      chk("ws_addr",  32'(HADDR), 32'h2000);
      chk("ws_wdata", HWDATA,     32'hCAFE_0300);
      @(negedge HCLK);
      if (s == 1) HREADYOUT = 1'b1;
      #1;
    end
    chk("ws_end_gnt",   32'(m_gnt), 32'h2);
    chk("ws_end_wdata", HWDATA,     32'hCAFE_0300);
    @(negedge HCLK);
    m_req = 2'b00; tr[1] = IDLE; wd[1] = 32'h3333_3333;
    HRESP = 1'b1; HRDATA = 32'h1234_5678; #1;
    chk("ws_m1_wdata", HWDATA,        32'h3333_3333);
    chk("resp_err",    32'(m_hresp),  32'h1);
    chk("resp_rdata",  m_hrdata,      32'h1234_5678);
    chk("resp_gnt",    32'(m_gnt),    32'h2);

    // Reset asserted during beat 2 of a burst.
    @(negedge HCLK); HRESP = 1'b0; m_req = 2'b01; tr[0] = NS; addr[0] = 16'h0400; #1;
    chk("mr_pre_gnt", 32'(m_gnt), 32'h2);
    @(negedge HCLK); #1;
    chk("mr_gnt0",   32'(m_gnt),  32'h1);
    chk("mr_trans0", 32'(HTRANS), 32'(NS));
    @(negedge HCLK); m_req = 2'b11; tr[0] = SQ; addr[0] = 16'h0404; tr[1] = NS; #1;
    chk("mr_trans1", 32'(HTRANS), 32'(SQ));
    @(negedge HCLK); addr[0] = 16'h0408; HRSTN = 1'b1; #1;
    chk("mr_rst_trans", 32'(HTRANS), 32'h0);
    chk("mr_rst_hsel",  32'(HSEL),   32'h0);
    @(negedge HCLK); #1;
    chk("mr_gnt",   32'(m_gnt),         32'h1);
    chk("mr_dvld",  32'(dut.data_vld),  32'h0);
    chk("mr_trans", 32'(HTRANS),        32'h0);
    chk("mr_wdata", HWDATA,             32'h0);
    @(negedge HCLK); HRSTN = 1'b0; m_req = 2'b00; tr[0] = IDLE; tr[1] = IDLE; #1;
    chk("mr_rel_gnt", 32'(m_gnt), 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Round-robin AHB-Lite arbiter sharing one 16-bit-address, 32-bit-data AHB slave between NUM_M masters.
- Grants the address phase to one master and tracks the data-phase owner separately, so address/data pipelining across a master switch is correct.
- Muxes master request buses onto the slave port and broadcasts slave responses back to all masters.

Parameters:
- NUM_M, 2, number of masters (2..8); master index 0 is the default/park master.

Ports:
- HCLK  in  1  clock.
- HRSTN  in  1  synchronous reset, active-high (1 = reset).
- m_req  in  NUM_M  per-master bus request.
- m_haddr  in  NUM_M*16  per-master HADDR, master i at [16i+15:16i].
- m_htrans  in  NUM_M*2  per-master HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- m_hwrite  in  NUM_M  per-master HWRITE.
- m_hsize  in  NUM_M*3  per-master HSIZE.
- m_hwdata  in  NUM_M*32  per-master HWDATA.
- m_gnt  out  NUM_M  one-hot address-phase grant.
- m_hready  out  1  broadcast HREADY (= HREADYOUT).
- m_hresp  out  1  broadcast HRESP.
- m_hrdata  out  32  broadcast HRDATA.
- HSEL  out  1  slave select.
- HADDR  out  16  slave address.
- HTRANS  out  2  slave transfer type.
- HWRITE  out  1  slave direction.
- HSIZE  out  3  slave size.
- HWDATA  out  32  slave write data.
- HREADY  out  1  slave HREADY input (= HREADYOUT).
- HREADYOUT  in  1  slave ready.
- HRESP  in  1  slave response.
- HRDATA  in  32  slave read data.

Behaviour:
- Reset values, held for every cycle HRSTN=1: m_gnt=1 (master 0 parked), rr pointer=0, data_vld=0, data_owner=0. Resulting outputs: HSEL=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
- Address phase (combinational from registered grant owner a):
  - HSEL = m_req[a].
  - HADDR, HWRITE, HSIZE come from master a.
  - HTRANS = m_htrans[a] when m_req[a]=1, else IDLE.
- Data phase (combinational from registered data_owner d):
  - HWDATA = m_hwdata[d] when data_vld=1, else 0.
- Responses: HREADY = m_hready = HREADYOUT; m_hresp = HRESP; m_hrdata = HRDATA.
- Data-phase tracking, at each edge with HREADYOUT=1:
  - data_vld <= HSEL & HTRANS[1].
  - data_owner <= a.
  - When HREADYOUT=0, data_vld and data_owner hold.
- Arbitration occurs only at edges with HREADYOUT=1. With HREADYOUT=0, m_gnt is frozen.
- Hold rule: keep the grant on a if m_req[a]=1 and m_htrans[a] is SEQ or BUSY. Bursts are never split.
- Otherwise, search from index (ptr+1) mod NUM_M upward for the first requester:
  - The winner gets m_gnt next cycle, and ptr <= winner.
  - If there are no requesters, m_gnt holds (park); ptr holds.
  - If a is the only requester, it is re-granted.
- Grant latency: m_req rises at edge N with the bus free → m_gnt visible after edge N+1. The master drives NONSEQ in that cycle, and it is forwarded the same cycle.
- Switch under pipelining: the old owner's data phase completes with its HWDATA while the new owner's address phase is on the bus.
- ERROR response (HRESP=1): passed through unchanged. Arbitration is unaffected.
- m_gnt is always one-hot. A non-granted master's signals never reach the slave.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority replaces round-robin. The lowest requesting index wins at each arbitration point. Hold rule and ptr register are unchanged, but ptr is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset: HRSTN=1 for 3 cycles with m_req=11 → m_gnt=01, HSEL=0, HTRANS=00 each cycle. After release, m_gnt=10 one edge later (ptr=0 → master 1 first).
- Single write: m0 req, NONSEQ HADDR=0x0040, HWRITE=1, HWDATA=0xDEADBEEF, HREADYOUT=1 → slave sees the address in cycle N and HWDATA=0xDEADBEEF in N+1.
- Round-robin: m0 and m1 both issue continuous single NONSEQ → m_gnt alternates 10,01,10,… every accepted transfer.
- Burst hold: m0 issues NONSEQ+3 SEQ (INCR4 from 0x0100) while m1 requests → m_gnt stays 01 for 4 beats and moves to 10 at the edge after the last beat. Slave sees 0x0100, 0x0104, 0x0108, 0x010C uninterrupted.
- Wait states at switch: m0 write in data phase with HREADYOUT=0 for 2 cycles while m1 holds the address phase → m_gnt, HADDR and HWDATA (m0 data) are stable during the stall. m1's data phase starts after HREADYOUT=1.
- Reset mid-burst, plus the ARB_FIXED_PRIO_EN build:
  - Assert HRSTN during SEQ beat 2 → next cycle HTRANS=IDLE, m_gnt=01, data_vld=0.
  - With the macro defined and m0/m1 continuously requesting singles → m0 always granted.
